ocl_axil_reg_bridge: RTL and testbench

- AXI-Lite slave front-end between the OCL register slice output and the Ising core register interface.
- Replaces ad hoc handshake glue with a protocol-correct bridge.
- Accepts AW and W independently, in either order, and issues single-cycle write strobes downstream.
- Issues read requests downstream and waits for data, with a timeout that returns a fixed error word.

---
 rtl/ocl_axil_reg_bridge.sv | 223 ++++++++++++++++++++++
 tb/tb_ocl_axil_reg_bridge.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocl_axil_reg_bridge.sv
// rtl/ocl_axil_reg_bridge.sv - AXI-Lite slave to single-cycle core register strobe bridge.
// Optional address range check enabled by defining OCL_BRIDGE_ADDR_CHECK_EN.
module ocl_axil_reg_bridge #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       RD_TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ERR_DATA   = 32'hDEAD_BEEF,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = 32'h0000_1000
) (
  input  logic                  clk,
  input  logic                  axi_rst,
  input  logic                  s_awvalid,
  input  logic [ADDR_W-1:0]     s_awaddr,
  output logic                  s_awready,
  input  logic                  s_wvalid,
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  output logic                  s_wready,
  output logic                  s_bvalid,
  output logic [1:0]            s_bresp,
  input  logic                  s_bready,
  input  logic                  s_arvalid,
  input  logic [ADDR_W-1:0]     s_araddr,
  output logic                  s_arready,
  output logic                  s_rvalid,
  output logic [DATA_W-1:0]     s_rdata,
  output logic [1:0]            s_rresp,
  input  logic                  s_rready,
  output logic                  reg_wr_en,
  output logic [ADDR_W-1:0]     reg_wr_addr,
  output logic [DATA_W-1:0]     reg_wr_data,
  output logic [DATA_W/8-1:0]   reg_wr_strb,
  output logic                  reg_rd_req,
  output logic [ADDR_W-1:0]     reg_rd_addr,
  input  logic                  reg_rd_valid,
  input  logic [DATA_W-1:0]     reg_rd_data
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam logic [15:0] TO_LAST = 16'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_STROBE, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} rd_state_e;

  wr_state_e           wr_state_q;
  logic                awready_q, wready_q, bvalid_q, wr_en_q;
  logic [1:0]          bresp_q;
  logic [ADDR_W-1:0]   aw_addr_q, wr_addr_q;
  logic [DATA_W-1:0]   w_data_q, wr_data_q;
  logic [STRB_W-1:0]   w_strb_q, wr_strb_q;

  rd_state_e           rd_state_q;
  logic                arready_q, rvalid_q, rd_req_q;
  logic [1:0]          rresp_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [15:0]         cnt_q;

  logic                aw_hs, w_hs, ar_hs, wr_go, wr_bad, ar_bad;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic [DATA_W-1:0]   wr_data_d;
  logic [STRB_W-1:0]   wr_strb_d;

  assign aw_hs = s_awvalid & awready_q;
  assign w_hs  = s_wvalid & wready_q;
  assign ar_hs = s_arvalid & arready_q;

  // A channel is present either because it handshakes now or was latched earlier.
  assign wr_go = (aw_hs | (wr_state_q == W_HAVE_AW)) & (w_hs | (wr_state_q == W_HAVE_W));

  assign wr_addr_d = (wr_state_q == W_HAVE_AW) ? aw_addr_q : s_awaddr;
  assign wr_data_d = (wr_state_q == W_HAVE_W)  ? w_data_q  : s_wdata;
  assign wr_strb_d = (wr_state_q == W_HAVE_W)  ? w_strb_q  : s_wstrb;

`ifdef OCL_BRIDGE_ADDR_CHECK_EN
  assign wr_bad = (wr_addr_d >= ADDR_LIMIT);
  assign ar_bad = (s_araddr >= ADDR_LIMIT);
`else
  assign wr_bad = 1'b0;
  assign ar_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      wr_en_q    <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (wr_state_q)
        W_IDLE, W_HAVE_AW, W_HAVE_W: begin
          if (aw_hs) aw_addr_q <= s_awaddr;
          if (w_hs) begin
            w_data_q <= s_wdata;
            w_strb_q <= s_wstrb;
          end
          if (wr_go) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            if (wr_bad) begin
              bvalid_q   <= 1'b1;
              bresp_q    <= 2'b11;
              wr_state_q <= W_RESP;
            end else begin
              wr_en_q    <= 1'b1;
              wr_addr_q  <= wr_addr_d;
              wr_data_q  <= wr_data_d;
              wr_strb_q  <= wr_strb_d;
              wr_state_q <= W_STROBE;
            end
          end else if (aw_hs) begin
            awready_q  <= 1'b0;
            wr_state_q <= W_HAVE_AW;
          end else if (w_hs) begin
            wready_q   <= 1'b0;
            wr_state_q <= W_HAVE_W;
          end
        end
        W_STROBE: begin
          bvalid_q   <= 1'b1;
          bresp_q    <= 2'b00;
          wr_state_q <= W_RESP;
        end
        W_RESP: begin
          if (s_bready) begin
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
      rd_addr_q  <= '0;
      cnt_q      <= '0;
    end else begin
      rd_req_q <= 1'b0;
      case (rd_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            arready_q <= 1'b0;
            if (ar_bad) begin
              rvalid_q   <= 1'b1;
              rdata_q    <= ERR_DATA;
              rresp_q    <= 2'b11;
              rd_state_q <= R_RESP;
            end else begin
              rd_addr_q  <= s_araddr;
              rd_req_q   <= 1'b1;
              rd_state_q <= R_REQ;
            end
          end
        end
        R_REQ: begin
          cnt_q      <= '0;
          rd_state_q <= R_WAIT;
        end
        R_WAIT: begin
          // Data arriving on the final counted cycle still beats the timeout.
          if (reg_rd_valid) begin
            rvalid_q   <= 1'b1;
            rdata_q    <= reg_rd_data;
            rresp_q    <= 2'b00;
            rd_state_q <= R_RESP;
          end else if (cnt_q == TO_LAST) begin
            rvalid_q   <= 1'b1;
            rdata_q    <= ERR_DATA;
            rresp_q    <= 2'b10;
            rd_state_q <= R_RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        R_RESP: begin
          if (s_rready) begin
            rvalid_q   <= 1'b0;
            rresp_q    <= 2'b00;
            arready_q  <= 1'b1;
            rd_state_q <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign s_awready   = awready_q;
  assign s_wready    = wready_q;
  assign s_bvalid    = bvalid_q;
  assign s_bresp     = bresp_q;
  assign s_arready   = arready_q;
  assign s_rvalid    = rvalid_q;
  assign s_rdata     = rdata_q;
  assign s_rresp     = rresp_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign reg_wr_strb = wr_strb_q;
  assign reg_rd_req  = rd_req_q;
  assign reg_rd_addr = rd_addr_q;

endmodule

// File: tb/tb_ocl_axil_reg_bridge.sv
// tb/tb_ocl_axil_reg_bridge.sv - directed bench with a transaction-level reference model.
// Address-check expectations follow OCL_BRIDGE_ADDR_CHECK_EN.
module tb_ocl_axil_reg_bridge;

  localparam int RD_TO = 4;

  logic        clk = 1'b0;
  logic        axi_rst = 1'b1;
  logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0;
  logic        s_arvalid = 1'b0, s_rready = 1'b0, reg_rd_valid = 1'b0;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0, reg_rd_data = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic        reg_wr_en, reg_rd_req;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata, reg_wr_addr, reg_wr_data, reg_rd_addr;
  logic [3:0]  reg_wr_strb;

  ocl_axil_reg_bridge #(.RD_TIMEOUT(RD_TO)) dut (
    .clk(clk), .axi_rst(axi_rst),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_wr_strb(reg_wr_strb), .reg_rd_req(reg_rd_req), .reg_rd_addr(reg_rd_addr),
    .reg_rd_valid(reg_rd_valid), .reg_rd_data(reg_rd_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int n_wr_en = 0, n_rd_req = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-transaction bookkeeping expressed as cycle numbers.
  int          cyc = 0;
  bit          m_have_aw, m_have_w, m_wdone, m_ar_pend, m_resolved;
  int          m_wr_en_cyc, m_bv_from, m_req_cyc, m_rv_from;
  logic [31:0] m_aw_addr, m_w_data, m_wr_addr, m_wr_data, m_rd_addr, m_rdata;
  logic [3:0]  m_w_strb, m_wr_strb;
  logic [1:0]  m_bresp, m_rresp;

  function automatic bit addr_bad(input logic [31:0] a);
`ifdef OCL_BRIDGE_ADDR_CHECK_EN
    return a >= 32'h1000;
`else
    return (a == a) && 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_have_aw = 0; m_have_w = 0; m_wdone = 0; m_ar_pend = 0; m_resolved = 0;
    m_wr_en_cyc = -1; m_bv_from = 0; m_req_cyc = -1; m_rv_from = 0;
    m_aw_addr = '0; m_w_data = '0; m_w_strb = '0; m_wr_addr = '0; m_wr_data = '0;
    m_wr_strb = '0; m_rd_addr = '0; m_rdata = '0; m_bresp = '0; m_rresp = '0;
  endtask

  function automatic bit e_bvalid(input int c);
    return m_wdone && c >= m_bv_from;
  endfunction

  function automatic bit e_rvalid(input int c);
    return m_ar_pend && m_resolved && c >= m_rv_from;
  endfunction

  always @(posedge clk) begin
    int cur;
    cur = cyc;
    if (axi_rst) model_reset();
    else begin
      if (e_bvalid(cur) && s_bready) begin
        m_have_aw = 0; m_have_w = 0; m_wdone = 0;
      end else begin
        if (s_awvalid && !m_have_aw) begin m_have_aw = 1; m_aw_addr = s_awaddr; end
        if (s_wvalid && !m_have_w) begin m_have_w = 1; m_w_data = s_wdata; m_w_strb = s_wstrb; end
        if (m_have_aw && m_have_w && !m_wdone) begin
          m_wdone = 1;
          if (addr_bad(m_aw_addr)) begin
            m_bv_from = cur + 1; m_bresp = 2'b11;
          end else begin
            m_wr_en_cyc = cur + 1; m_bv_from = cur + 2; m_bresp = 2'b00;
            m_wr_addr = m_aw_addr; m_wr_data = m_w_data; m_wr_strb = m_w_strb;
          end
        end
      end
      if (e_rvalid(cur) && s_rready) begin
        m_ar_pend = 0; m_resolved = 0;
      end else if (!m_ar_pend) begin
        if (s_arvalid) begin
          m_ar_pend = 1;
          if (addr_bad(s_araddr)) begin
            m_resolved = 1; m_rv_from = cur + 1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b11;
          end else begin
            m_req_cyc = cur + 1; m_rd_addr = s_araddr;
          end
        end
      end else if (!m_resolved && cur > m_req_cyc) begin
        if (reg_rd_valid) begin
          m_resolved = 1; m_rv_from = cur + 1; m_rdata = reg_rd_data; m_rresp = 2'b00;
        end else if (cur == m_req_cyc + RD_TO) begin
          m_resolved = 1; m_rv_from = cur + 1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b10;
        end
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (axi_rst) begin
      chk("rst_awready", s_awready, 1);   chk("rst_wready", s_wready, 1);
      chk("rst_arready", s_arready, 1);   chk("rst_bvalid", s_bvalid, 0);
      chk("rst_bresp", s_bresp, 0);       chk("rst_rvalid", s_rvalid, 0);
      chk("rst_rdata", s_rdata, 0);       chk("rst_rresp", s_rresp, 0);
      chk("rst_wr_en", reg_wr_en, 0);     chk("rst_wr_addr", reg_wr_addr, 0);
      chk("rst_wr_data", reg_wr_data, 0); chk("rst_wr_strb", reg_wr_strb, 0);
      chk("rst_rd_req", reg_rd_req, 0);   chk("rst_rd_addr", reg_rd_addr, 0);
    end else begin
      if (reg_wr_en) n_wr_en++;
      if (reg_rd_req) n_rd_req++;
      chk("m_awready", s_awready, !m_have_aw);
      chk("m_wready", s_wready, !m_have_w);
      chk("m_bvalid", s_bvalid, e_bvalid(cyc));
      if (e_bvalid(cyc)) chk("m_bresp", s_bresp, m_bresp);
      chk("m_wr_en", reg_wr_en, cyc == m_wr_en_cyc);
      chk("m_wr_addr", reg_wr_addr, m_wr_addr);
      chk("m_wr_data", reg_wr_data, m_wr_data);
      chk("m_wr_strb", reg_wr_strb, m_wr_strb);
      chk("m_arready", s_arready, !m_ar_pend);
      chk("m_rd_req", reg_rd_req, m_ar_pend && cyc == m_req_cyc);
      chk("m_rd_addr", reg_rd_addr, m_rd_addr);
      chk("m_rvalid", s_rvalid, e_rvalid(cyc));
      if (e_rvalid(cyc)) begin
        chk("m_rdata", s_rdata, m_rdata);
        chk("m_rresp", s_rresp, m_rresp);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_rvalid(input string nm);
    for (int i = 0; i < 20 && !s_rvalid; i++) tick();
    chk(nm, s_rvalid, 1);
  endtask

  initial begin
    int wr0, rd0;
    model_reset();
    repeat (3) tick();
    axi_rst = 1'b0;
    tick();

    // Same-cycle AW and W
    s_awvalid = 1; s_awaddr = 32'h10; s_wvalid = 1; s_wdata = 32'hA5; s_wstrb = 4'hF; s_bready = 1;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    chk("t1_wr_en", reg_wr_en, 1);     chk("t1_addr", reg_wr_addr, 32'h10);
    chk("t1_data", reg_wr_data, 32'hA5); chk("t1_strb", reg_wr_strb, 4'hF);
    chk("t1_bvalid_early", s_bvalid, 0);
    tick();
    chk("t1_bvalid", s_bvalid, 1);     chk("t1_bresp", s_bresp, 0);
    chk("t1_wr_en_once", reg_wr_en, 0);
    tick();
    chk("t1_bdone", s_bvalid, 0);      chk("t1_awready", s_awready, 1);

    // W first, AW three cycles later
    s_wvalid = 1; s_wdata = 32'h1234; s_wstrb = 4'h3;
    tick();
    s_wvalid = 0;
    chk("t2_wready_wait", s_wready, 0); chk("t2_awready_wait", s_awready, 1);
    tick(); tick();
    chk("t2_wready_still", s_wready, 0);
    s_awvalid = 1; s_awaddr = 32'h20;
    tick();
    s_awvalid = 0;
    chk("t2_wr_en", reg_wr_en, 1);     chk("t2_addr", reg_wr_addr, 32'h20);
    chk("t2_data", reg_wr_data, 32'h1234);
    tick(); tick();
    chk("t2_one_strobe", n_wr_en, 2);

    // AW first, W next cycle, bready held low
    s_bready = 0;
    s_awvalid = 1; s_awaddr = 32'h44;
    tick();
    s_awvalid = 0; s_wvalid = 1; s_wdata = 32'hAABB_CCDD; s_wstrb = 4'hC;
    tick();
    s_wvalid = 0;
    chk("t2b_addr", reg_wr_addr, 32'h44); chk("t2b_strb", reg_wr_strb, 4'hC);
    repeat (3) tick();
    chk("t2b_bheld", s_bvalid, 1);
    s_bready = 1;
    tick();

    // Read with data next cycle and stalled rready
    s_arvalid = 1; s_araddr = 32'h08; s_rready = 0;
    tick();
    chk("t3_rd_req", reg_rd_req, 1);   chk("t3_rd_addr", reg_rd_addr, 32'h08);
    tick();
    reg_rd_valid = 1; reg_rd_data = 32'hCAFE;
    tick();
    reg_rd_valid = 0; s_arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_rvalid", s_rvalid, 1); chk("t3_rdata", s_rdata, 32'hCAFE); chk("t3_rresp", s_rresp, 0);
      tick();
    end
    s_rready = 1;
    tick();
    s_rready = 0;
    chk("t3_rdone", s_rvalid, 0);      chk("t3_single_ar", n_rd_req, 1);

    // Timeout, then a late reg_rd_valid that must be ignored
    s_arvalid = 1; s_araddr = 32'h0C;
    tick();
    s_arvalid = 0;
    for (int i = 0; i < RD_TO; i++) begin tick(); chk("t4_wait", s_rvalid, 0); end
    tick();
    chk("t4_rvalid", s_rvalid, 1);     chk("t4_rdata", s_rdata, 32'hDEAD_BEEF);
    chk("t4_rresp", s_rresp, 2'b10);
    reg_rd_valid = 1; reg_rd_data = 32'h5555;
    tick(); tick();
    reg_rd_valid = 0;
    chk("t4_late_ignored", s_rdata, 32'hDEAD_BEEF);
    s_rready = 1; tick(); s_rready = 0;

    // Data on the last waiting cycle beats the timeout
    s_arvalid = 1; s_araddr = 32'h18;
    tick();
    s_arvalid = 0;
    repeat (RD_TO - 1) tick();
    tick();
    reg_rd_valid = 1; reg_rd_data = 32'h7777;
    tick();
    reg_rd_valid = 0;
    chk("t4b_rdata", s_rdata, 32'h7777); chk("t4b_rresp", s_rresp, 0);
    s_rready = 1; tick(); s_rready = 0;

    // Reset during read WAIT
    s_arvalid = 1; s_araddr = 32'h24;
    tick();
    s_arvalid = 0;
    tick();
    #1 axi_rst = 1;
    #1 chk("t5_r_arready", s_arready, 1); chk("t5_r_rvalid", s_rvalid, 0);
    tick();
    axi_rst = 0;
    tick();

    // Reset during write RESP
    s_bready = 0;
    s_awvalid = 1; s_awaddr = 32'h28; s_wvalid = 1; s_wdata = 32'h99; s_wstrb = 4'h1;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    tick();
    chk("t5_w_bvalid", s_bvalid, 1);
    #1 axi_rst = 1;
    #1 chk("t5_w_bdrop", s_bvalid, 0); chk("t5_w_awready", s_awready, 1);
    chk("t5_w_wready", s_wready, 1);
    tick();
    axi_rst = 0; s_bready = 1;
    tick();

    // Recovery: simultaneous write strobe and read request
    s_awvalid = 1; s_awaddr = 32'h30; s_wvalid = 1; s_wdata = 32'hBEEF_0001; s_wstrb = 4'h5;
    s_arvalid = 1; s_araddr = 32'h40;
    tick();
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    chk("t5_both_wr", reg_wr_en, 1);   chk("t5_both_rd", reg_rd_req, 1);
    tick();
    reg_rd_valid = 1; reg_rd_data = 32'h4444;
    tick();
    reg_rd_valid = 0;
    chk("t5_rec_rdata", s_rdata, 32'h4444);
    s_rready = 1; tick(); s_rready = 0;
    tick();

    // Out-of-range addresses
    wr0 = n_wr_en; rd0 = n_rd_req;
    s_awvalid = 1; s_awaddr = 32'h1000; s_wvalid = 1; s_wdata = 32'h11; s_wstrb = 4'hF;
    s_arvalid = 1; s_araddr = 32'h2000;
    tick();
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
`ifdef OCL_BRIDGE_ADDR_CHECK_EN
    chk("t6_bvalid", s_bvalid, 1);     chk("t6_bresp", s_bresp, 2'b11);
    chk("t6_rvalid", s_rvalid, 1);     chk("t6_rresp", s_rresp, 2'b11);
    chk("t6_rdata", s_rdata, 32'hDEAD_BEEF);
    s_rready = 1; tick(); s_rready = 0;
    tick();
    chk("t6_no_wr", n_wr_en, wr0);     chk("t6_no_rd", n_rd_req, rd0);
`else
    chk("t6_wr_fwd", reg_wr_en, 1);    chk("t6_wr_addr", reg_wr_addr, 32'h1000);
    chk("t6_rd_fwd", reg_rd_req, 1);   chk("t6_rd_addr", reg_rd_addr, 32'h2000);
    wait_rvalid("t6_rvalid");
    chk("t6_rresp", s_rresp, 2'b10);   chk("t6_rdata", s_rdata, 32'hDEAD_BEEF);
    s_rready = 1; tick(); s_rready = 0;
    tick();
    chk("t6_one_wr", n_wr_en, wr0 + 1);
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
